// File: rtl/nx_host_bridge_pkg.sv
// Shared types and constants for the Nexus host bridge.
// Message layout, host beat width, beat count and the egress FSM state enum.
package nx_host_bridge_pkg;

  localparam int NX_HOST_WIDTH = 8;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [7:0]  addr;
    logic [15:0] data;
  } nx_message_t;

  localparam int NX_MSG_BITS = $bits(nx_message_t);

  // Host beats per message; pad bits sit at the top of beat 0.
  function automatic int nx_msg_beats(input int host_width);
    return (NX_MSG_BITS + host_width - 1) / host_width;
  endfunction

  function automatic int nx_idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int NX_MSG_BYTES = nx_msg_beats(NX_HOST_WIDTH);

  typedef enum logic {
    NX_TX_IDLE = 1'b0,
    NX_TX_SEND = 1'b1
  } nx_bridge_tx_state_t;

endpackage

// File: rtl/nx_msg_serialiser.sv
// Egress half of the host bridge: captures one message from the control
// outbound port and plays it out MSB-first as host beats.
//
// state      | meaning
// NX_TX_IDLE | ready for a new message, no host beat offered
// NX_TX_SEND | message captured, offering beat tx_idx to the host
module nx_msg_serialiser
  import nx_host_bridge_pkg::*;
#(
  parameter int HOST_WIDTH = NX_HOST_WIDTH,
  parameter int MSG_BYTES  = NX_MSG_BYTES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  nx_message_t           msg_i,
  input  logic                  msg_valid_i,
  output logic                  msg_ready_o,
  output logic [HOST_WIDTH-1:0] byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  sending_o
);

  localparam int VEC_W = MSG_BYTES * HOST_WIDTH;
  localparam int IDX_W = nx_idx_width(MSG_BYTES);
  localparam logic [IDX_W-1:0] TX_LAST = IDX_W'(MSG_BYTES - 1);

  nx_bridge_tx_state_t   state_q;
  logic [VEC_W-1:0]      msg_q;
  logic [IDX_W-1:0]      tx_idx_q;
  logic [HOST_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ready_q;

  logic [VEC_W-1:0]      cap_vec;
  logic [IDX_W-1:0]      tx_next;

  // Zero-extension drives the pad bits of beat 0 low.
  assign cap_vec = VEC_W'(msg_i);
  assign tx_next = tx_idx_q + IDX_W'(1);

  // Egress FSM with registered handshake outputs and byte mux.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= NX_TX_IDLE;
      msg_q    <= '0;
      tx_idx_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        NX_TX_IDLE: begin
          if (msg_valid_i && ready_q) begin
            msg_q    <= cap_vec;
            tx_idx_q <= '0;
            data_q   <= cap_vec[VEC_W-1 -: HOST_WIDTH];
            valid_q  <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= NX_TX_SEND;
          end else begin
            ready_q <= 1'b1;
          end
        end
        NX_TX_SEND: begin
          if (byte_ready_i) begin
            if (tx_idx_q == TX_LAST) begin
              valid_q <= 1'b0;
              data_q  <= '0;
              ready_q <= 1'b1;
              state_q <= NX_TX_IDLE;
            end else begin
              tx_idx_q <= tx_next;
              data_q   <= msg_q[(MSG_BYTES - 1 - int'(tx_next)) * HOST_WIDTH +: HOST_WIDTH];
            end
          end
        end
        default: state_q <= NX_TX_IDLE;
      endcase
    end
  end

  assign msg_ready_o  = ready_q;
  assign byte_o       = data_q;
  assign byte_valid_o = valid_q;
  assign sending_o    = (state_q == NX_TX_SEND);

endmodule

// File: rtl/nx_host_bridge.sv
// Host-side endpoint of the Nexus control streams: assembles host beats into
// messages for the control inbound port and serialises control outbound
// messages back to host beats.
// Optional feature: define NX_HOST_BRIDGE_TIMEOUT_EN to drop a partial inbound
// message after TIMEOUT_CYCLES idle cycles.
module nx_host_bridge
  import nx_host_bridge_pkg::*;
#(
  parameter int HOST_WIDTH     = NX_HOST_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [HOST_WIDTH-1:0] host_ib_data_i,
  input  logic                  host_ib_valid_i,
  output logic                  host_ib_ready_o,
  output logic [HOST_WIDTH-1:0] host_ob_data_o,
  output logic                  host_ob_valid_o,
  input  logic                  host_ob_ready_i,
  output nx_message_t           ctrl_ib_data_o,
  output logic                  ctrl_ib_valid_o,
  input  logic                  ctrl_ib_ready_i,
  input  nx_message_t           ctrl_ob_data_i,
  input  logic                  ctrl_ob_valid_i,
  output logic                  ctrl_ob_ready_o,
  output logic                  rx_timeout_o,
  output logic                  busy_o
);

  localparam int MSG_BYTES = nx_msg_beats(HOST_WIDTH);
  localparam int VEC_W     = MSG_BYTES * HOST_WIDTH;
  localparam int IDX_W     = nx_idx_width(MSG_BYTES);
  localparam logic [IDX_W-1:0] RX_LAST = IDX_W'(MSG_BYTES - 1);

  logic [IDX_W-1:0]            rx_idx_q;
  logic [VEC_W-HOST_WIDTH-1:0] asm_q;
  nx_message_t                 hold_q;
  logic                        hold_valid_q;
  logic                        ib_ready_q;
  logic                        tx_sending;

  logic                        rx_accept;
  logic                        rx_last;
  logic                        rx_drop;
  logic [VEC_W-1:0]            rx_vec;
  logic                        unused_pad;

  assign rx_accept  = host_ib_valid_i && ib_ready_q;
  assign rx_last    = (rx_idx_q == RX_LAST);
  assign rx_vec     = {asm_q, host_ib_data_i};
  assign unused_pad = ^rx_vec[VEC_W-1:NX_MSG_BITS];

  // Ingress assembly, holding register and registered host ready.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_idx_q     <= '0;
      asm_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ib_ready_q   <= 1'b0;
    end else begin
      if (rx_accept) begin
        asm_q    <= {asm_q[VEC_W-2*HOST_WIDTH-1:0], host_ib_data_i};
        rx_idx_q <= rx_last ? '0 : rx_idx_q + IDX_W'(1);
      end else if (rx_drop) begin
        rx_idx_q <= '0;
      end
      if (rx_accept && rx_last) begin
        hold_q       <= nx_message_t'(rx_vec[NX_MSG_BITS-1:0]);
        hold_valid_q <= 1'b1;
      end else if (hold_valid_q && ctrl_ib_ready_i) begin
        hold_valid_q <= 1'b0;
      end
      // Ready next cycle only if the holding register will be empty.
      ib_ready_q <= !((rx_accept && rx_last) || (hold_valid_q && !ctrl_ib_ready_i));
    end
  end

`ifdef NX_HOST_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_pulse_q;

  // Rx_idx is 0 whenever the holding register is full; the gate keeps that explicit.
  assign rx_drop = (rx_idx_q != '0) && !hold_valid_q && !rx_accept && (to_cnt_q == '0);

  // Idle down-counter, reloaded on every accepted beat and while no message is in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt_q   <= TO_LOAD;
      to_pulse_q <= 1'b0;
    end else begin
      to_pulse_q <= rx_drop;
      if (rx_accept || (rx_idx_q == '0)) begin
        to_cnt_q <= TO_LOAD;
      end else if (!hold_valid_q && (to_cnt_q != '0)) begin
        to_cnt_q <= to_cnt_q - TO_W'(1);
      end
    end
  end

  assign rx_timeout_o = to_pulse_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign rx_drop      = 1'b0;
  assign rx_timeout_o = 1'b0;
`endif

  nx_msg_serialiser #(
    .HOST_WIDTH (HOST_WIDTH),
    .MSG_BYTES  (MSG_BYTES)
  ) u_serialiser (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .msg_i        (ctrl_ob_data_i),
    .msg_valid_i  (ctrl_ob_valid_i),
    .msg_ready_o  (ctrl_ob_ready_o),
    .byte_o       (host_ob_data_o),
    .byte_valid_o (host_ob_valid_o),
    .byte_ready_i (host_ob_ready_i),
    .sending_o    (tx_sending)
  );

  assign host_ib_ready_o = ib_ready_q;
  assign ctrl_ib_data_o  = hold_q;
  assign ctrl_ib_valid_o = hold_valid_q;
  assign busy_o          = (rx_idx_q != '0) || hold_valid_q || tx_sending;

endmodule
